// File: rtl/scan_pkg.sv
// Shared types and defaults for the array scan reader.
// Holds the scan FSM state encoding and the default array geometry.
package scan_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/array_scan_reader_if.sv
// Bundle of write-port, scan-control and streaming-output signals.
// The master modport is the driving environment; the slave modport is the reader.
interface array_scan_reader_if
    import scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW-1:0]    lo;
    logic [AW-1:0]    hi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             busy;
    logic             done;
    logic [AW:0]      count;

    modport master (
        output wr_en, wr_addr, wr_data, start, lo, hi, out_ready,
        input  out_valid, out_data, out_addr, busy, done, count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, lo, hi, out_ready,
        output out_valid, out_data, out_addr, busy, done, count
    );

endinterface

// File: rtl/array_scan_reader_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational
// read port, cleared asynchronously by rst.
module scan_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/array_scan_reader.sv
// Streams a contiguous index range of the register array out over valid/ready,
// one entry per accepted beat, in ascending order.
module array_scan_reader
    import scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    array_scan_reader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    scan_state_t      r_state;
    scan_state_t      w_next;
    logic [AW-1:0]    r_hi;
    logic [AW-1:0]    r_out_addr;
    logic [WIDTH-1:0] r_out_data;
    logic [AW:0]      r_count;

    logic             w_load;
    logic             w_capture;
    logic             w_clr_cnt;
    logic             w_inc_cnt;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;

    scan_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The read port address is whichever index the next beat will be loaded from.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_clr_cnt = 1'b0;
        w_inc_cnt = 1'b0;
        w_rd_addr = bus.lo;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_clr_cnt = 1'b1;
                    if (bus.lo <= bus.hi) begin
                        w_capture = 1'b1;
                        w_load    = 1'b1;
                        w_next    = SCAN;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    w_inc_cnt = 1'b1;
                    if (r_out_addr == r_hi) begin
                        w_next = DONE;
                    end else begin
                        w_load    = 1'b1;
                        w_rd_addr = r_out_addr + AW'(1);
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi       <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_count    <= '0;
        end else begin
            if (w_capture) begin
                r_hi <= bus.hi;
            end
            if (w_load) begin
                r_out_addr <= w_rd_addr;
                r_out_data <= w_rd_data;
            end
            if (w_clr_cnt) begin
                r_count <= '0;
            end else if (w_inc_cnt) begin
                r_count <= r_count + (AW+1)'(1);
            end
        end
    end

    assign bus.out_valid = (r_state == SCAN);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.count     = r_count;

endmodule
